// File: rtl/wb_arbiter_pkg.sv
// Shared register-file constants and the write-back entry type used by the
// write-back arbiter and its long-latency result buffer.
package wb_arbiter_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam int WbBufDepth = 2;

    localparam logic [RegBus-1:0] ZeroWord = '0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic RstEnable    = 1'b1;

    typedef logic [RegBus-1:0]     reg_data_t;
    typedef logic [RegAddrBus-1:0] reg_addr_t;

    // 37-bit buffered result: destination register and its value
    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending long-latency results; a push while full and a pop
// while empty are ignored, so the caller never corrupts the occupancy count.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WbBufDepth
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW:0]   count;
    wb_entry_t       mem [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FullCount);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count
    // already makes every stale slot unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Single writer of the integer register file: merges pipeline results with
// buffered long-latency results and tracks registers awaiting the latter.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = WbBufDepth,
    parameter int REG_NUM   = RegNum
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_we_i,
    input  logic [4:0]  a_waddr_i,
    input  logic [31:0] a_wdata_i,
    input  logic        b_valid_i,
    input  logic [4:0]  b_waddr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_ready_o,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_waddr_i,
    output logic        iss_busy_o,
    input  logic [4:0]  chk_raddr1_i,
    input  logic [4:0]  chk_raddr2_i,
    output logic        stall_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o
);

    wb_entry_t          b_entry;
    wb_entry_t          head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               a_active;
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;

    assign b_entry  = '{addr: b_waddr_i, data: b_wdata_i};
    assign b_ready_o = !full;
    // A result for x0 is accepted on the handshake but never stored.
    assign push     = b_valid_i && b_ready_o && (b_waddr_i != '0);
    assign a_active = (a_we_i == WriteEnable) && (a_waddr_i != '0);
    assign pop      = !a_active && !empty;

    wb_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (b_entry),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // NOTE: combinational blocks use blocking assignments so later lines see
    // earlier ones; placing the set after the clear makes a new issue win.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.addr] = 1'b0;
        if (iss_valid_i && (iss_waddr_i != '0)) busy_next[iss_waddr_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            busy    <= '0;
            we_o    <= WriteDisable;
            waddr_o <= '0;
            wdata_o <= ZeroWord;
        end else begin
            busy <= busy_next;
            if (a_active) begin
                we_o    <= WriteEnable;
                waddr_o <= a_waddr_i;
                wdata_o <= a_wdata_i;
            end else if (pop) begin
                we_o    <= WriteEnable;
                waddr_o <= head.addr;
                wdata_o <= head.data;
            end else begin
                we_o <= WriteDisable;
            end
        end
    end

    assign iss_busy_o = busy[iss_waddr_i];
    assign stall_o    = busy[chk_raddr1_i] || busy[chk_raddr2_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// registered write, and a monitor compares it against the port after each edge.
module tb_wb_arbiter;

    localparam int BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_we = 1'b0;
    logic [4:0]  a_waddr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_valid = 1'b0;
    logic [4:0]  b_waddr = '0;
    logic [31:0] b_wdata = '0;
    logic        b_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_waddr = '0;
    logic        iss_busy;
    logic [4:0]  chk1 = '0;
    logic [4:0]  chk2 = '0;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    wb_arbiter #(.BUF_DEPTH(BUF_DEPTH), .REG_NUM(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_we_i       (a_we),
        .a_waddr_i    (a_waddr),
        .a_wdata_i    (a_wdata),
        .b_valid_i    (b_valid),
        .b_waddr_i    (b_waddr),
        .b_wdata_i    (b_wdata),
        .b_ready_o    (b_ready),
        .iss_valid_i  (iss_valid),
        .iss_waddr_i  (iss_waddr),
        .iss_busy_o   (iss_busy),
        .chk_raddr1_i (chk1),
        .chk_raddr2_i (chk2),
        .stall_o      (stall),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          due;
    } op_t;

    // Reference model state
    wr_t         exp_q[$];
    logic [36:0] mq[$];
    bit   [31:0] mbusy;
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    op_t         unit_q[$];
    bit          allow_reissue = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        unit_q.delete();
        mbusy       = '0;
        m_last_addr = '0;
        m_last_data = '0;
    endtask

    task automatic idle();
        a_we = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; predicts the next
    // rising edge, queues the expected write and returns on the next falling edge.
    task automatic step(output bit acc);
        bit          a_act;
        bit          ready;
        wr_t         e;
        logic [36:0] h;
        #1;
        ready = (mq.size() < BUF_DEPTH);
        check("b_ready", b_ready, ready);
        check("stall", stall, (chk1 != 0 && mbusy[chk1]) || (chk2 != 0 && mbusy[chk2]));
        check("iss_busy", iss_busy, (iss_waddr != 0) && mbusy[iss_waddr]);
        if (iss_valid && iss_waddr != 0 && mbusy[iss_waddr] && !allow_reissue) begin
            errors++;
            $display("FAIL illegal_issue: x%0d issued while pending", iss_waddr);
        end
        a_act = a_we && (a_waddr != 0);
        if (a_act) begin
            e = '{1'b1, a_waddr, a_wdata};
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e = '{1'b1, h[36:32], h[31:0]};
            mbusy[h[36:32]] = 1'b0;
        end else begin
            e = '{1'b0, m_last_addr, m_last_data};
        end
        m_last_addr = e.addr;
        m_last_data = e.data;
        if (iss_valid && iss_waddr != 0) mbusy[iss_waddr] = 1'b1;
        acc = b_valid && ready;
        if (acc && b_waddr != 0) mq.push_back({b_waddr, b_wdata});
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares the registered write port after every rising edge.
    always begin
        wr_t e;
        @(posedge clk);
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("we", we, e.we);
            check("waddr", waddr, e.addr);
            check("wdata", wdata, e.data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        logic [4:0] r;
        model_reset();

        // Reset state while asserted
        @(negedge clk);
        #1;
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_b_ready", b_ready, 1);
        check("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // Pipeline write x5 = 0x1234, then idle
        a_we = 1'b1; a_waddr = 5; a_wdata = 32'h1234;
        step(acc);
        idle();
        step(acc);
        step(acc);

        // Issue x7, stall on it, then its long-latency result returns
        iss_valid = 1'b1; iss_waddr = 7;
        step(acc);
        idle(); chk1 = 7;
        step(acc);
        b_valid = 1'b1; b_waddr = 7; b_wdata = 32'hDEAD;
        step(acc);
        b_valid = 1'b0;
        step(acc);
        step(acc);

        // A busy three cycles while B queues x3 and x4
        iss_valid = 1'b1; iss_waddr = 3; step(acc);
        iss_waddr = 4; step(acc);
        iss_valid = 1'b0; chk1 = 3; chk2 = 4;
        a_we = 1'b1; a_waddr = 1; a_wdata = 32'hA1;
        b_valid = 1'b1; b_waddr = 3; b_wdata = 32'h333;
        step(acc);
        a_waddr = 2; a_wdata = 32'hA2;
        b_waddr = 4; b_wdata = 32'h444;
        step(acc);
        a_waddr = 6; a_wdata = 32'hA3; b_valid = 1'b0;
        step(acc);
        idle();
        repeat (3) step(acc);

        // Same-edge issue and pop of x9: set wins
        chk1 = 9; chk2 = 0;
        iss_valid = 1'b1; iss_waddr = 9; step(acc);
        iss_valid = 1'b0;
        b_valid = 1'b1; b_waddr = 9; b_wdata = 32'h99;
        step(acc);
        b_valid = 1'b0;
        allow_reissue = 1'b1; iss_valid = 1'b1; iss_waddr = 9;
        step(acc);
        allow_reissue = 1'b0; iss_valid = 1'b0;
        step(acc);
        b_valid = 1'b1; b_waddr = 9; b_wdata = 32'h77;
        step(acc);
        b_valid = 1'b0;
        repeat (2) step(acc);

        // x0 result is accepted but never counted or written
        iss_valid = 1'b1; iss_waddr = 10; step(acc);
        iss_waddr = 11; step(acc);
        iss_valid = 1'b0;
        a_we = 1'b1; a_waddr = 12; a_wdata = 32'hC0;
        b_valid = 1'b1; b_waddr = 10; b_wdata = 32'h1010; step(acc);
        b_waddr = 0; b_wdata = 32'hFFFF; step(acc);
        b_waddr = 11; b_wdata = 32'h1111; step(acc);
        b_valid = 1'b0; step(acc);
        idle();
        repeat (3) step(acc);

        // Reset mid-cycle with two queued entries and x3/x4 busy
        iss_valid = 1'b1; iss_waddr = 3; step(acc);
        iss_waddr = 4; step(acc);
        iss_valid = 1'b0;
        a_we = 1'b1; a_waddr = 13; a_wdata = 32'hD0;
        b_valid = 1'b1; b_waddr = 3; b_wdata = 32'h3; step(acc);
        b_waddr = 4; b_wdata = 32'h4; step(acc);
        idle(); chk1 = 3; chk2 = 4;
        #2 rst = 1'b1;
        #1;
        check("midrst_we", we, 0);
        check("midrst_waddr", waddr, 0);
        check("midrst_wdata", wdata, 0);
        check("midrst_b_ready", b_ready, 1);
        check("midrst_stall", stall, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(acc);

        // Randomized traffic with an in-order long-latency unit
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_we = ($urandom_range(0, 99) < 45);
            a_waddr = 5'($urandom_range(0, 31));
            a_wdata = $urandom();
            iss_valid = 1'b0;
            iss_waddr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 25 && unit_q.size() < 6) begin
                r = 5'($urandom_range(1, 31));
                if (!mbusy[r]) begin
                    iss_valid = 1'b1;
                    iss_waddr = r;
                end
            end
            if (!b_valid && unit_q.size() > 0 && unit_q[0].due <= cyc &&
                $urandom_range(0, 99) < 70) begin
                b_valid = 1'b1;
                b_waddr = unit_q[0].addr;
                b_wdata = unit_q[0].data;
            end
            chk1 = 5'($urandom_range(0, 31));
            chk2 = 5'($urandom_range(0, 31));
            step(acc);
            if (acc) begin
                void'(unit_q.pop_front());
                b_valid = 1'b0;
            end
            if (iss_valid)
                unit_q.push_back('{iss_waddr, $urandom(), cyc + int'($urandom_range(1, 8))});
            if ($urandom_range(0, 99) < 4)
                unit_q.push_back('{5'd0, $urandom(), cyc + 1});
        end

        // Drain outstanding results
        a_we = 1'b0; iss_valid = 1'b0;
        for (int i = 0; i < 200 && (unit_q.size() > 0 || mq.size() > 0 || b_valid); i++) begin
            if (!b_valid && unit_q.size() > 0) begin
                b_valid = 1'b1;
                b_waddr = unit_q[0].addr;
                b_wdata = unit_q[0].data;
            end
            step(acc);
            if (acc) begin
                void'(unit_q.pop_front());
                b_valid = 1'b0;
            end
        end
        check("drain_unit", unit_q.size(), 0);
        check("drain_busy", mbusy, 0);
        repeat (2) step(acc);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and scoreboard that is the single writer of the integer register file. Each cycle it merges two result sources into the register file's one write port (`we`/`waddr`/`wdata`):
- the in-order pipeline result (ALU or load from the MEM/WB stage), which has priority and no backpressure;
- a long-latency unit's results (for example a divider), buffered in a small in-order FIFO.

It also tracks which registers still await a long-latency result and raises a stall to decode when an operand read targets one.

## Interface
Parameters:
- `BUF_DEPTH`, default 2: long-latency result FIFO entries; must be a power of two and at least 2.
- `REG_NUM`, default 32: architectural registers; x0 is hardwired to zero.

Ports:
- `clk` in 1: sole clock; everything is sampled on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_we_i` in 1: pipeline result valid; always accepted.
- `a_waddr_i` in 5: pipeline destination register.
- `a_wdata_i` in 32: pipeline result data.
- `b_valid_i` in 1: long-latency result valid.
- `b_waddr_i` in 5: long-latency destination register.
- `b_wdata_i` in 32: long-latency result data.
- `b_ready_o` out 1: FIFO can accept a long-latency result.
- `iss_valid_i` in 1: a long-latency op is issued this cycle.
- `iss_waddr_i` in 5: destination of the issued op.
- `iss_busy_o` out 1: `iss_waddr_i` is already pending; issue is illegal this cycle.
- `chk_raddr1_i` in 5: decode operand 1 address.
- `chk_raddr2_i` in 5: decode operand 2 address.
- `stall_o` out 1: an operand is pending; decode must stall.
- `we_o` out 1: register-file write enable (registered).
- `waddr_o` out 5: register-file write address (registered).
- `wdata_o` out 32: register-file write data (registered).

## Operation
Long-latency FIFO (B side):
- Handshake: a transfer happens when `b_valid_i` and `b_ready_o` are both high.
- `b_ready_o` = FIFO not full. There is no pass-through when full, so a push is never accepted while full.
- A B transfer with `b_waddr_i` = 0 is accepted and discarded; it is not enqueued.
- Source must hold `b_valid_i`, `b_waddr_i` and `b_wdata_i` stable until the transfer is accepted.

Write-port arbitration, evaluated each cycle:
- If `a_we_i` is high and `a_waddr_i` ≠ 0, register A onto the outputs. The FIFO head waits.
- Otherwise, if the FIFO is not empty, pop the head and register it onto the outputs.
- Otherwise, `we_o` = 0 and `waddr_o`/`wdata_o` hold their last values.
- An A write with `a_waddr_i` = 0 counts as idle, so B may use that cycle.

Scoreboard:
- `busy[1..REG_NUM-1]` holds one bit per register; x0 is never busy.
- Set on an edge where `iss_valid_i` is high and `iss_waddr_i` ≠ 0.
- Cleared on the edge where a popped FIFO entry for that register is registered onto the outputs.
- If the same register is set and cleared on one edge, set wins.
- A writes never touch the busy bits.
- A B result with `b_waddr_i` = 0 never clears anything.

Combinational outputs:
- `iss_busy_o` = `busy[iss_waddr_i]`. Upstream must not issue while it is high. Behaviour for an issue to a busy register is undefined; the bench flags it.
- `stall_o` = `busy[chk_raddr1_i]` or `busy[chk_raddr2_i]`. Address 0 never stalls.

## Timing
- Reset is asynchronous. While reset is asserted and after release: `we_o` = 0, `waddr_o` = 0, `wdata_o` = 0, FIFO empty, all busy bits 0, `b_ready_o` = 1, `stall_o` = 0.
- Reset mid-operation discards any buffered B results.
- A latency: input on cycle N appears on `we_o` in cycle N+1. The register file commits it at the end of cycle N+1.
- B latency: accepted at edge E, the result is on the outputs from edge E+1 at the earliest, if A is idle in the cycle after E.
- Each cycle A is active, every queued B result is delayed by one cycle.
- Busy clears on the same edge that `we_o` goes high for that register. Decode's read in that cycle therefore sees `stall_o` = 0, and the register file's write-through path supplies the data.
- FIFO count, for the edge-triggered update:
  - push alone: +1;
  - pop alone: −1;
  - push and pop together: unchanged.
- FIFO read and write pointers wrap modulo `BUF_DEPTH`.

## Structure
- Use the existing shared defines header for: `RegBus`, `RegAddrBus`, `RegNum`, `ZeroWord`, `WriteEnable`, `WriteDisable`, `RstEnable`.
- Add `WbBufDepth` there as the default for `BUF_DEPTH`.
- Sub-module `wb_fifo`: a synchronous FIFO holding 37-bit {addr, data} entries.
  - Signals: push, pop, full, empty, head.
  - Reset: asynchronous.
- Keep the arbiter, the scoreboard and the output registers in `wb_arbiter`.

## Test plan
- Reset release, then A writes x5 = 0x1234 → `we_o` = 1, `waddr_o` = 5, `wdata_o` = 0x1234 exactly one cycle later; `we_o` = 0 the next cycle.
- Issue x7; decode checks `chk_raddr1_i` = 7 → `stall_o` = 1. Then B returns x7 = 0xDEAD with A idle → write appears one cycle after acceptance, and `stall_o` = 0 in that same cycle.
- A active for 3 consecutive cycles while B pushes x3 and x4:
  - `b_ready_o` drops once 2 entries are queued;
  - queued x3 then x4 are written in the two cycles after A goes idle;
  - then `b_ready_o` = 1.
- Same edge: issue x9 while the FIFO pops an earlier x9 → `busy[9]` remains 1 and `stall_o` stays high for x9. Separately, B with `b_waddr_i` = 0 → accepted, no write, FIFO count unchanged.
- Assert `rst` mid-cycle with 2 queued entries and busy x3/x4 → outputs immediately 0, `b_ready_o` = 1, `stall_o` = 0, no later writes of x3/x4.
